fb_frame_sequencer: RTL
=======================

// Module: fb_frame_sequencer
// PURPOSE
//  Frame-level controller for the double-buffered framebuffer. Owns the framebuffer write port:
//  each frame it clears the back buffer, lets the renderer write into it, then toggles SEL_CLK
//  at vertical blank to swap front/back. Sits between the render engine, the VGA timing
//  generator (VSYNC_START) and framebuffer_double (SEL_CLK, RENDER_EN, RENDER_INDEX, FB_IN).
// PARAMETERS
//  DATA_WIDTH   4            pixel colour-index width
//  ADDR_WIDTH   16           framebuffer address width
//  PIXELS       64000        valid pixels per frame (<= 2**ADDR_WIDTH); addresses 0..PIXELS-1
//  CLEAR_COLOR  0            colour written to every pixel during CLEAR
// PORTS
//  CLK           in   1           system clock (same clock as framebuffer CLK)
//  RESET         in   1           asynchronous, active-high reset
//  VSYNC_START   in   1           one-cycle pulse at start of vertical blank
//  render_req    in   1           renderer write valid
//  render_addr   in   ADDR_WIDTH  renderer pixel address
//  render_data   in   DATA_WIDTH  renderer pixel colour
//  render_done   in   1           one-cycle pulse: renderer finished this frame
//  render_start  out  1           one-cycle pulse: back buffer cleared, renderer may begin
//  render_ready  out  1           high while renderer writes are accepted (RENDER state)
//  SEL_CLK       out  1           buffer-swap pulse to framebuffer_double (registered, glitch-free)
//  RENDER_EN     out  1           framebuffer write enable
//  RENDER_INDEX  out  ADDR_WIDTH  framebuffer write address
//  FB_IN         out  DATA_WIDTH  framebuffer write data
//  frame_count   out  8           completed swaps, wraps 255->0
//  late_frames   out  8           VSYNC_START seen before frame ready, saturates at 255
//  addr_err      out  1           sticky: renderer wrote address >= PIXELS
// BEHAVIOUR
//  - All outputs registered. On RESET: state=IDLE, every output 0, clear counter 0.
//  - States IDLE -> CLEAR -> RENDER -> WAIT_VS -> SWAP -> CLEAR ...
//  - IDLE: one cycle after reset release, unconditionally -> CLEAR.
//  - CLEAR: counter 0..PIXELS-1, one pixel per cycle: RENDER_EN=1, RENDER_INDEX=counter,
//    FB_IN=CLEAR_COLOR. After writing PIXELS-1 -> RENDER; render_start=1 for exactly the
//    first RENDER cycle. render_ready=0 throughout CLEAR; render_req ignored.
//  - RENDER: render_ready=1. Accepted write (render_req=1) appears on RENDER_EN/RENDER_INDEX/
//    FB_IN the next cycle (latency 1). render_addr >= PIXELS: write dropped (RENDER_EN=0),
//    addr_err set until RESET. render_done -> WAIT_VS; a render_req in the same cycle as
//    render_done is still accepted.
//  - WAIT_VS: no writes. On VSYNC_START -> SWAP.
//  - SWAP: SEL_CLK=1 for exactly this one cycle; frame_count+1; next -> CLEAR, counter 0.
//  - VSYNC_START in CLEAR or RENDER (including the render_done cycle): late_frames+1
//    (saturating), no swap; swap waits for the next VSYNC_START in WAIT_VS.
//  - VSYNC_START in IDLE or SWAP: ignored, not counted.
//  - RENDER_EN=0 in IDLE, WAIT_VS, SWAP and on cycles with no accepted render write.
//  - Reset mid-operation: immediate return to IDLE state values; clear restarts from 0.
//  - SEL_CLK is a clock to framebuffer_double: drive directly from a flop, never from logic.
// TESTING (PIXELS=16 in simulation)
//  - Release RESET -> 1 IDLE cycle, then 16 cycles RENDER_EN=1, INDEX 0..15, FB_IN=0; then
//    render_start high 1 cycle, render_ready=1.
//  - In RENDER, req addr=5 data=0xA -> next cycle RENDER_EN=1, INDEX=5, FB_IN=0xA;
//    addr=20 -> RENDER_EN=0, addr_err=1 and stays 1.
//  - render_done, VSYNC_START 3 cycles later -> SEL_CLK=1 for 1 cycle, frame_count 0->1,
//    CLEAR restarts at INDEX 0.
//  - VSYNC_START during RENDER -> late_frames=1, no SEL_CLK; swap occurs on next VSYNC after done.
//  - render_done and VSYNC_START same cycle -> late_frames+1, no swap until following VSYNC.
//  - RESET asserted while CLEAR at INDEX 7 -> all outputs 0 immediately; after release clear
//    restarts at INDEX 0.

Source files
------------

// File: rtl/fb_frame_sequencer.sv
// Frame-level controller for the double-buffered framebuffer: clears the back buffer,
// forwards renderer writes, and pulses SEL_CLK at vertical blank to swap buffers.
module fb_frame_sequencer #(
    parameter int DATA_WIDTH  = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int PIXELS      = 64000,
    parameter int CLEAR_COLOR = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  VSYNC_START,
    input  logic                  render_req,
    input  logic [ADDR_WIDTH-1:0] render_addr,
    input  logic [DATA_WIDTH-1:0] render_data,
    input  logic                  render_done,
    output logic                  render_start,
    output logic                  render_ready,
    output logic                  SEL_CLK,
    output logic                  RENDER_EN,
    output logic [ADDR_WIDTH-1:0] RENDER_INDEX,
    output logic [DATA_WIDTH-1:0] FB_IN,
    output logic [7:0]            frame_count,
    output logic [7:0]            late_frames,
    output logic                  addr_err
);

    localparam logic [ADDR_WIDTH:0]   PIX_LIMIT = (ADDR_WIDTH+1)'(PIXELS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXELS - 1);
    localparam logic [DATA_WIDTH-1:0] CLR_VAL   = DATA_WIDTH'(CLEAR_COLOR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RENDER,
        S_WAIT_VS,
        S_SWAP
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   cnt_reg, cnt_next;
    logic                    start_reg, start_next;
    logic                    ready_reg, ready_next;
    logic                    sel_clk_reg, sel_clk_next;
    logic                    en_reg, en_next;
    logic [ADDR_WIDTH-1:0]   index_reg, index_next;
    logic [DATA_WIDTH-1:0]   data_reg, data_next;
    logic [7:0]              frame_reg, frame_next;
    logic [7:0]              late_reg, late_next;
    logic                    err_reg, err_next;
    logic                    addr_ok;

    assign addr_ok = ({1'b0, render_addr} < PIX_LIMIT);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        start_next   = 1'b0;
        sel_clk_next = 1'b0;
        en_next      = 1'b0;
        index_next   = '0;
        data_next    = '0;
        frame_next   = frame_reg;
        late_next    = late_reg;
        err_next     = err_reg;

        case (state_reg)
            S_IDLE, S_SWAP: begin
                // Outputs are registered, so the first clear write is set up on entry
                state_next = S_CLEAR;
                cnt_next   = '0;
                en_next    = 1'b1;
                data_next  = CLR_VAL;
            end
            S_CLEAR: begin
                if (VSYNC_START && late_reg != 8'hFF)
                    late_next = late_reg + 8'd1;
                if (cnt_reg == LAST_ADDR) begin
                    state_next = S_RENDER;
                    start_next = 1'b1;
                end else begin
                    cnt_next   = cnt_reg + 1'b1;
                    en_next    = 1'b1;
                    index_next = cnt_reg + 1'b1;
                    data_next  = CLR_VAL;
                end
            end
            S_RENDER: begin
                if (VSYNC_START && late_reg != 8'hFF)
                    late_next = late_reg + 8'd1;
                if (render_req) begin
                    if (addr_ok) begin
                        en_next    = 1'b1;
                        index_next = render_addr;
                        data_next  = render_data;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                if (render_done)
                    state_next = S_WAIT_VS;
            end
            S_WAIT_VS: begin
                if (VSYNC_START) begin
                    state_next   = S_SWAP;
                    sel_clk_next = 1'b1;
                    frame_next   = frame_reg + 8'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        ready_next = (state_next == S_RENDER);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            start_reg   <= 1'b0;
            ready_reg   <= 1'b0;
            sel_clk_reg <= 1'b0;
            en_reg      <= 1'b0;
            index_reg   <= '0;
            data_reg    <= '0;
            frame_reg   <= '0;
            late_reg    <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            start_reg   <= start_next;
            ready_reg   <= ready_next;
            sel_clk_reg <= sel_clk_next;
            en_reg      <= en_next;
            index_reg   <= index_next;
            data_reg    <= data_next;
            frame_reg   <= frame_next;
            late_reg    <= late_next;
            err_reg     <= err_next;
        end
    end

    // SEL_CLK clocks the framebuffer, so it comes straight from its flop
    assign SEL_CLK      = sel_clk_reg;
    assign render_start = start_reg;
    assign render_ready = ready_reg;
    assign RENDER_EN    = en_reg;
    assign RENDER_INDEX = index_reg;
    assign FB_IN        = data_reg;
    assign frame_count  = frame_reg;
    assign late_frames  = late_reg;
    assign addr_err     = err_reg;

endmodule
